// File: rtl/emailbox_mc_pkg.sv
// emailbox_mc_pkg: shared register map and address decode type for the mailbox
package emailbox_mc_pkg;
`include "emailbox_mc_regmap.vh"
    typedef struct packed {
        logic       hit;
        logic [3:0] ch;
        logic [5:0] idx;
    } dec_t;
endpackage

// File: rtl/emailbox_mc_chan.sv
// emailbox_mc_chan: one mailbox channel - FWFT FIFO, count, threshold, irq enable, overflow, hi-hold
// ports: push/din from emesh, rd_lo/cfg_* from register port; read views lo_data/hi_hold/stat/cfg; prog_full, irq
module emailbox_mc_chan
    import emailbox_mc_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int THRESH = DEPTH - 4
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        push,
    input  logic [63:0] din,
    input  logic        rd_lo,
    input  logic        cfg_we,
    input  logic        cfg_irq_en,
    input  logic        cfg_ovf_clr,
    input  logic [7:0]  cfg_thresh,
    output logic [31:0] lo_data,
    output logic [31:0] hi_hold,
    output logic [31:0] stat,
    output logic [31:0] cfg,
    output logic        prog_full,
    output logic        irq
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;
    logic [63:0]     mem [DEPTH];
    logic [PTRW-1:0] wp, rp;
    logic [CW-1:0]   count;
    logic [7:0]      thresh;
    logic            irq_en, ovf, not_empty, full, pop, wr;
    assign not_empty = count != '0;
    assign full      = count == CW'(DEPTH);
    assign pop       = rd_lo & not_empty;
    // a pop in the same cycle frees the slot, so a full channel still accepts the push
    assign wr        = push & (~full | pop);
    assign prog_full = 16'(count) >= 16'(thresh);
    assign irq       = irq_en & (not_empty | prog_full | ovf);
    assign lo_data   = not_empty ? mem[rp][31:0] : '0;
    always_comb begin
        stat = '0;
        stat[STAT_CNT_LSB +: 16] = 16'(count);
        stat[STAT_THR_LSB +: 8] = thresh;
        stat[STAT_OVF] = ovf;
        stat[STAT_PFULL] = prog_full;
        stat[STAT_FULL] = full;
        stat[STAT_NE] = not_empty;
        cfg = '0;
        cfg[CFG_THR_LSB +: 8] = thresh;
        cfg[CFG_IRQ_EN] = irq_en;
    end
    always_ff @(posedge clk)
        if (wr) mem[wp] <= din;
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            thresh  <= 8'(THRESH);
            irq_en  <= 1'b0;
            ovf     <= 1'b0;
            hi_hold <= '0;
        end else begin
            if (wr) wp <= wp + PTRW'(1);
            if (pop) begin
                rp      <= rp + PTRW'(1);
                hi_hold <= mem[rp][63:32];
            end
            count <= count + CW'(wr) - CW'(pop);
            if (cfg_we) begin
                irq_en <= cfg_irq_en;
                thresh <= cfg_thresh;
            end
            // a dropped push in the same cycle as a W1C clear leaves the flag set
            ovf <= (ovf & ~(cfg_we & cfg_ovf_clr)) | (push & full & ~pop);
        end
endmodule

// File: rtl/emailbox_mc_regmap.vh
// emailbox_mc_regmap: register indexes, group decode constants and STAT/CFG bit positions
`ifndef EMAILBOX_MC_REGMAP_VH
`define EMAILBOX_MC_REGMAP_VH
localparam logic [5:0] REG_LO       = 6'hC;
localparam logic [5:0] REG_HI       = 6'hD;
localparam logic [5:0] REG_STAT     = 6'hE;
localparam logic [5:0] REG_CFG      = 6'hF;
localparam logic [3:0] GRP_HI       = 4'hF;
localparam logic [2:0] GRP_LO       = 3'h7;
localparam int         STAT_NE      = 0;
localparam int         STAT_FULL    = 1;
localparam int         STAT_PFULL   = 2;
localparam int         STAT_OVF     = 3;
localparam int         STAT_THR_LSB = 8;
localparam int         STAT_CNT_LSB = 16;
localparam int         CFG_IRQ_EN   = 0;
localparam int         CFG_OVF_CLR  = 1;
localparam int         CFG_THR_LSB  = 8;
`endif

// File: rtl/packet2emesh.sv
// packet2emesh: splits an emesh packet into its fields
// ports: packet in; write, datamode, ctrlmode, dstaddr, srcaddr, data out
module packet2emesh #(
    parameter int AW = 32,
    parameter int PW = 2*AW+40
) (
    input  logic [PW-1:0] packet,
    output logic          write,
    output logic [1:0]    datamode,
    output logic [4:0]    ctrlmode,
    output logic [AW-1:0] dstaddr,
    output logic [AW-1:0] srcaddr,
    output logic [AW-1:0] data
);
    assign write    = packet[0];
    assign datamode = packet[2:1];
    assign ctrlmode = packet[7:3];
    assign dstaddr  = packet[8 +: AW];
    assign data     = packet[8+AW +: AW];
    assign srcaddr  = packet[8+2*AW +: AW];
endmodule

// File: rtl/emailbox_mc.sv
// emailbox_mc: multi-channel emesh mailbox with per-channel FIFOs and register readback
// ports: clk, nreset; emesh_access/packet pushes messages; reg_access/packet reads/writes registers;
//        reg_rdata (1-cycle latency), mailbox_irq/_any, mailbox_wait (prog_full)
module emailbox_mc
    import emailbox_mc_pkg::*;
#(
    parameter int         AW     = 32,
    parameter int         PW     = 2*AW+40,
    parameter logic [11:0] ID    = 12'h000,
    parameter int         NCH    = 4,
    parameter int         DEPTH  = 16,
    parameter int         THRESH = DEPTH - 4
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           emesh_access,
    input  logic [PW-1:0]  emesh_packet,
    input  logic           reg_access,
    input  logic [PW-1:0]  reg_packet,
    output logic [31:0]    reg_rdata,
    output logic [NCH-1:0] mailbox_irq,
    output logic           mailbox_irq_any,
    output logic [NCH-1:0] mailbox_wait
);
    logic          e_write, r_write;
    logic [1:0]    e_dm, r_dm;
    logic [4:0]    e_cm, r_cm;
    logic [AW-1:0] e_dst, e_src, e_dat, r_dst, r_src, r_dat;
    dec_t          ed, rd;
    logic          e_lo, r_rd, r_cfg;
    logic [31:0]   rd_val;
    logic [31:0]   lo [NCH];
    logic [31:0]   hi [NCH];
    logic [31:0]   st [NCH];
    logic [31:0]   cf [NCH];
    logic [31:0]   rv [NCH];
    logic [NCH-1:0] pf, irq;
    logic          unused_ok;
    packet2emesh #(.AW(AW), .PW(PW)) u_e2m (
        .packet(emesh_packet), .write(e_write), .datamode(e_dm), .ctrlmode(e_cm),
        .dstaddr(e_dst), .srcaddr(e_src), .data(e_dat)
    );
    packet2emesh #(.AW(AW), .PW(PW)) u_r2m (
        .packet(reg_packet), .write(r_write), .datamode(r_dm), .ctrlmode(r_cm),
        .dstaddr(r_dst), .srcaddr(r_src), .data(r_dat)
    );
    assign ed = '{hit: e_dst[31:20] == ID && e_dst[19:16] == GRP_HI && e_dst[10:8] == GRP_LO,
                  ch: e_dst[15:12], idx: e_dst[7:2]};
    assign rd = '{hit: r_dst[31:20] == ID && r_dst[19:16] == GRP_HI && r_dst[10:8] == GRP_LO,
                  ch: r_dst[15:12], idx: r_dst[7:2]};
    assign e_lo  = emesh_access & e_write & ed.hit & (ed.idx == REG_LO);
    assign r_rd  = reg_access & ~r_write & rd.hit;
    assign r_cfg = reg_access & r_write & rd.hit & (rd.idx == REG_CFG);
    // channels >= NCH have no instance, so their pushes, writes and reads fall away
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        emailbox_mc_chan #(.DEPTH(DEPTH), .THRESH(THRESH)) u_chan (
            .clk(clk),
            .nreset(nreset),
            .push(e_lo && ed.ch == 4'(c)),
            .din({e_src[31:0], e_dat[31:0]}),
            .rd_lo(r_rd && rd.idx == REG_LO && rd.ch == 4'(c)),
            .cfg_we(r_cfg && rd.ch == 4'(c)),
            .cfg_irq_en(r_dat[CFG_IRQ_EN]),
            .cfg_ovf_clr(r_dat[CFG_OVF_CLR]),
            .cfg_thresh(r_dat[CFG_THR_LSB +: 8]),
            .lo_data(lo[c]),
            .hi_hold(hi[c]),
            .stat(st[c]),
            .cfg(cf[c]),
            .prog_full(pf[c]),
            .irq(irq[c])
        );
        assign rv[c] = rd.idx == REG_LO   ? lo[c] :
                       rd.idx == REG_HI   ? hi[c] :
                       rd.idx == REG_STAT ? st[c] :
                       rd.idx == REG_CFG  ? cf[c] : '0;
    end
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NCH; i++)
            if (rd.ch == 4'(i)) rd_val = rv[i];
    end
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) reg_rdata <= '0;
        else         reg_rdata <= r_rd ? rd_val : '0;
    // gated so a zero threshold cannot raise wait while in reset
    assign mailbox_wait    = nreset ? pf : '0;
    assign mailbox_irq     = irq;
    assign mailbox_irq_any = |irq;
    assign unused_ok = ^{e_dm, e_cm, r_dm, r_cm, r_src, r_dat, e_dst, r_dst, e_src, e_dat};
endmodule

// File: tb/tb_emailbox_mc.sv
// tb_emailbox_mc: directed scoreboard bench for emailbox_mc (NCH=4, DEPTH=16, THRESH=12)
module tb_emailbox_mc;
    localparam logic [5:0] LO = 6'hC, HI = 6'hD, STAT = 6'hE, CFG = 6'hF;
    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         emesh_access = 1'b0;
    logic [103:0] emesh_packet = '0;
    logic         reg_access = 1'b0;
    logic [103:0] reg_packet = '0;
    logic [31:0]  reg_rdata;
    logic [3:0]   mailbox_irq, mailbox_wait;
    logic         mailbox_irq_any;
    int           asserts = 0;
    int           fails = 0;
    logic [31:0]  exp_q[$];
    string        name_q[$];
    logic [8:0]   oq[$];
    string        oname_q[$];
    logic         vld_d;
    emailbox_mc #(.AW(32), .PW(104), .ID(12'h000), .NCH(4), .DEPTH(16), .THRESH(12)) dut (
        .clk(clk), .nreset(nreset),
        .emesh_access(emesh_access), .emesh_packet(emesh_packet),
        .reg_access(reg_access), .reg_packet(reg_packet),
        .reg_rdata(reg_rdata), .mailbox_irq(mailbox_irq),
        .mailbox_irq_any(mailbox_irq_any), .mailbox_wait(mailbox_wait)
    );
    always #5 clk = ~clk;
    function automatic logic [103:0] pkt(input logic w, input logic [31:0] dst, input logic [31:0] dat, input logic [31:0] src);
        return {src, dat, dst, 5'b0, 2'b10, w};
    endfunction
    function automatic logic [31:0] adr(input int ch, input logic [5:0] idx);
        logic [3:0] c;
        c = 4'(ch);
        return {12'h000, 4'hF, c, 1'b0, 3'h7, idx, 2'b00};
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
        emesh_access = 1'b0;
        reg_access = 1'b0;
    endtask
    task automatic push(input int ch, input logic [31:0] src, input logic [31:0] dat);
        emesh_access = 1'b1;
        emesh_packet = pkt(1'b1, adr(ch, LO), dat, src);
        step();
    endtask
    task automatic rd(input string n, input int ch, input logic [5:0] idx, input logic [31:0] e);
        reg_access = 1'b1;
        reg_packet = pkt(1'b0, adr(ch, idx), 32'h0, 32'h0);
        exp_q.push_back(e);
        name_q.push_back(n);
        step();
    endtask
    task automatic wr_cfg(input int ch, input logic [31:0] dat);
        reg_access = 1'b1;
        reg_packet = pkt(1'b1, adr(ch, CFG), dat, 32'h0);
        step();
    endtask
    task automatic expect_outs(input string n, input logic any, input logic [3:0] irq, input logic [3:0] wt);
        oq.push_back({any, irq, wt});
        oname_q.push_back(n);
    endtask
    always @(posedge clk or negedge nreset)
        if (!nreset) vld_d <= 1'b0;
        else         vld_d <= reg_access & ~reg_packet[0];
    always @(negedge clk) begin
        logic [31:0] e;
        logic [8:0]  oe;
        string       n;
        asserts++;
        if (vld_d) begin
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rdata_extra: reg_rdata=%h with no read expected", reg_rdata);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (reg_rdata !== e) begin
                    fails++;
                    $display("FAIL %s: reg_rdata=%h required %h", n, reg_rdata, e);
                end
            end
        end else if (reg_rdata !== 32'h0) begin
            fails++;
            $display("FAIL rdata_idle: reg_rdata=%h required 00000000", reg_rdata);
        end
        if (oq.size() != 0) begin
            asserts++;
            oe = oq.pop_front();
            n = oname_q.pop_front();
            if ({mailbox_irq_any, mailbox_irq, mailbox_wait} !== oe) begin
                fails++;
                $display("FAIL %s: {irq_any,irq,wait}=%b required %b", n,
                         {mailbox_irq_any, mailbox_irq, mailbox_wait}, oe);
            end
        end
    end
    initial begin
        repeat (3) @(posedge clk);
        #1;
        expect_outs("reset_outs", 1'b0, 4'h0, 4'h0);
        @(negedge clk);
        #1;
        nreset = 1'b1;
        step();
        // ch2 push and read back LO, HI, STAT
        push(2, 32'h1111_2222, 32'hAAAA_BBBB);
        rd("ch2_stat_one", 2, STAT, 32'h0001_0C01);
        rd("ch2_lo", 2, LO, 32'hAAAA_BBBB);
        rd("ch2_hi", 2, HI, 32'h1111_2222);
        rd("ch2_hi_again", 2, HI, 32'h1111_2222);
        rd("ch2_stat_empty", 2, STAT, 32'h0000_0C00);
        // ch0 overflow
        for (int i = 0; i < 17; i++) push(0, 32'h100 + 32'(i), 32'h5000 + 32'(i));
        rd("ch0_stat_ovf", 0, STAT, 32'h0010_0C0F);
        expect_outs("ch0_wait", 1'b0, 4'h0, 4'b0001);
        wr_cfg(0, 32'h2);
        rd("ch0_stat_clr", 0, STAT, 32'h0010_0007);
        rd("ch0_lo_first", 0, LO, 32'h5000);
        rd("ch0_hi_first", 0, HI, 32'h100);
        // ch1 prog_full boundary at threshold 12
        for (int i = 0; i < 11; i++) push(1, 32'h0, 32'h6000 + 32'(i));
        expect_outs("ch1_wait_11", 1'b0, 4'h0, 4'b0001);
        push(1, 32'h0, 32'h600B);
        expect_outs("ch1_wait_12", 1'b0, 4'h0, 4'b0011);
        rd("ch1_lo", 1, LO, 32'h6000);
        expect_outs("ch1_wait_pop", 1'b0, 4'h0, 4'b0001);
        // ch3 full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push(3, 32'h7100 + 32'(i), 32'h7000 + 32'(i));
        emesh_access = 1'b1;
        emesh_packet = pkt(1'b1, adr(3, LO), 32'h7FFF, 32'h7EEE);
        rd("ch3_lo_pushpop", 3, LO, 32'h7000);
        rd("ch3_stat_pushpop", 3, STAT, 32'h0010_0C07);
        for (int i = 1; i < 16; i++) rd($sformatf("ch3_lo_%0d", i), 3, LO, 32'h7000 + 32'(i));
        rd("ch3_lo_last", 3, LO, 32'h7FFF);
        rd("ch3_hi_last", 3, HI, 32'h7EEE);
        rd("ch3_stat_empty", 3, STAT, 32'h0000_0C00);
        // interrupts and empty / out-of-range reads
        expect_outs("irq_off", 1'b0, 4'h0, 4'b0001);
        wr_cfg(1, 32'h0C01);
        expect_outs("irq_ch1", 1'b1, 4'b0010, 4'b0001);
        rd("ch1_cfg", 1, CFG, 32'h0000_0C01);
        rd("ch2_lo_empty", 2, LO, 32'h0);
        rd("ch2_hi_kept", 2, HI, 32'h1111_2222);
        push(6, 32'h1, 32'h2);
        wr_cfg(9, 32'h0C01);
        rd("ch5_stat_oor", 5, STAT, 32'h0);
        rd("ch2_stat_still_empty", 2, STAT, 32'h0000_0C00);
        // reset with 5 entries queued and a read in flight
        for (int i = 0; i < 5; i++) push(2, 32'h0, 32'h8000 + 32'(i));
        reg_access = 1'b1;
        reg_packet = pkt(1'b0, adr(2, LO), 32'h0, 32'h0);
        @(posedge clk);
        #2;
        nreset = 1'b0;
        reg_access = 1'b0;
        expect_outs("reset_mid_outs", 1'b0, 4'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        step();
        rd("ch2_stat_reset", 2, STAT, 32'h0000_0C00);
        rd("ch1_cfg_reset", 1, CFG, 32'h0000_0C00);
        rd("ch0_stat_reset", 0, STAT, 32'h0000_0C00);
        expect_outs("outs_after_reset", 1'b0, 4'h0, 4'h0);
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/emailbox_mc.md
EMAILBOX_MC -- requirements
Module: emailbox_mc

Interface
REQ-001 SHALL have parameter AW, default 32, meaning emesh address/data width.
REQ-002 SHALL have parameter PW, default 2*AW+40, meaning emesh packet width.
REQ-003 SHALL have parameter ID, default 12'h000, meaning link id matched against addr[31:20].
REQ-004 SHALL have parameter NCH, default 4, meaning mailbox channel count (1..16).
REQ-005 SHALL have parameter DEPTH, default 16, meaning per-channel FIFO depth (power of 2, 4..256).
REQ-006 SHALL have parameter THRESH, default DEPTH-4, meaning reset value of the prog_full threshold.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port nreset, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port emesh_access, input, 1 bit: message packet valid.
REQ-010 SHALL have port emesh_packet, input, PW bits: message packet.
REQ-011 SHALL have port reg_access, input, 1 bit: register packet valid.
REQ-012 SHALL have port reg_packet, input, PW bits: register read or write packet.
REQ-013 SHALL have port reg_rdata, output, 32 bits: register readback.
REQ-014 SHALL have port mailbox_irq, output, NCH bits: per-channel interrupt.
REQ-015 SHALL have port mailbox_irq_any, output, 1 bit: OR of mailbox_irq.
REQ-016 SHALL have port mailbox_wait, output, NCH bits: per-channel prog_full pushback.

Function
REQ-017 SHALL decode addresses as follows: hit when addr[31:20]==ID, addr[19:16]==4'hF and addr[10:8]==3'h7; channel = addr[15:12]; register index = addr[7:2].
REQ-018 SHALL define these register indexes per channel: LO=6'hC, HI=6'hD, STAT=6'hE, CFG=6'hF.
REQ-019 SHALL push {srcaddr,data} (64 bits) into channel c on an emesh write hit to LO of c, in the same clock edge.
REQ-020 SHALL drop a push to a full channel and set that channel's sticky overflow flag; FIFO contents are unchanged.
REQ-021 SHALL silently drop pushes and register writes to channel >= NCH; reads of channel >= NCH SHALL return 0.
REQ-022 SHALL handle a register read of LO on a non-empty channel as follows: return head[31:0], latch head[63:32] into that channel's hi-hold register, and pop.
REQ-023 SHALL make the FIFO head first-word-fall-through, so a pop is visible at the head on the next cycle.
REQ-024 SHALL, on a read of LO on an empty channel, return 0, not pop, and leave hi-hold unchanged.
REQ-025 SHALL return hi-hold on a read of HI; hi-hold is not popped or cleared by the read.
REQ-026 SHALL return STAT = {count zero-extended to 16b [31:16], threshold [15:8], 4'b0, overflow [3], prog_full [2], full [1], not_empty [0]}.
REQ-027 SHALL return CFG = {16'b0, threshold [15:8], 7'b0, irq_en [0]}.
REQ-028 SHALL treat a CFG register write as follows: data[0] sets irq_en, data[15:8] sets threshold, and data[1]=1 clears overflow (W1C).
REQ-029 SHALL have 1-cycle read latency: reg_rdata valid the cycle after reg_access with a read, and 0 in all other cycles.
REQ-030 SHALL, on a simultaneous push and pop of the same channel, perform both; count unchanged, and a full channel SHALL accept the push.
REQ-031 SHALL compute prog_full = count >= threshold; mailbox_wait[c] = prog_full[c].
REQ-032 SHALL drive mailbox_irq[c] = irq_en[c] & (not_empty[c] | prog_full[c] | overflow[c]) as a level signal.
REQ-033 SHALL use wrap-around read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits, saturating at 0..DEPTH.

Reset
REQ-034 SHALL, on nreset low, asynchronously empty all FIFOs and clear overflow, irq_en, hi-hold and reg_rdata, and load threshold with THRESH.
REQ-035 SHALL drive all outputs 0 while nreset is low; FIFO memory contents need not be reset.
REQ-036 SHALL discard a read that is in flight when reset asserts; the first cycle after release returns reg_rdata=0.

Structure
REQ-037 SHALL place the register indexes, group constants (4'hF, 3'h7) and STAT/CFG bit positions in shared include emailbox_mc_regmap.vh.
REQ-038 SHALL decode packets with packet2emesh (one instance per interface).
REQ-039 SHALL implement per-channel storage as sub-module emailbox_mc_chan (FIFO, count, threshold, irq_en, overflow, hi-hold), instantiated NCH times via generate.

Verification
REQ-040 SHALL cover: push 0x1111_2222/0xAAAA_BBBB to ch2, read LO then HI -> 0xAAAA_BBBB, then 0x1111_2222, then STAT.not_empty=0.
REQ-041 SHALL cover: DEPTH=16, 17 pushes to ch0 -> STAT full=1, overflow=1, count=16; CFG write 0x2 -> overflow=0.
REQ-042 SHALL cover: threshold=12, 12 pushes to ch1 -> mailbox_wait[1]=1; one LO read -> mailbox_wait[1]=0 the next cycle.
REQ-043 SHALL cover: ch3 full, push and LO read in the same cycle -> count stays 16, overflow=0, FIFO order preserved.
REQ-044 SHALL cover: irq_en=0 with data pending -> mailbox_irq_any=0; CFG write 0x1 -> mailbox_irq[c]=1; LO read of empty ch -> rdata 0, no pop.
REQ-045 SHALL cover: nreset asserted with 5 entries queued and a read in flight -> all outputs 0 immediately; after release, STAT.count=0 and threshold=THRESH.
